apb_master_bridge: RTL and testbench

- Initiator end of the APB link: accepts single read/write commands on a valid/ready command port, runs the APB SETUP/ACCESS sequence on the bus, and returns the result on a valid/ready response port.
- Drives the bus toward the dual-port memory slave, both in RTL integration and as the reference initiator in block-level benches.
- One transfer outstanding at a time.
- Bounded PREADY wait: a stalled slave is aborted and reported as an error.

---
 rtl/apb_master_bridge_if.sv | 33 +++
 rtl/apb_master_bridge.sv | 128 ++++++++++++
 tb/tb_apb_master_bridge.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_bridge_if.sv
// Command, response and APB bus signals of the APB initiator bridge.
// The master modport is the bridge's view; the slave modport is the environment's view.
interface apb_master_bridge_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic                  PWRITE;
    logic                  PSEL;
    logic                  PENABLE;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, PADDR, PWRITE, PSEL, PENABLE, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, PADDR, PWRITE, PSEL, PENABLE, PWDATA
    );
endinterface

// File: rtl/apb_master_bridge.sv
// APB initiator: one command at a time through SETUP/ACCESS, result on the response port.
// A slave holding PREADY low for TIMEOUT_CYCLES ACCESS cycles is aborted with rsp_err.
module apb_master_bridge #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input logic                 PCLK,
    input logic                 PRESETn,
    apb_master_bridge_if.master bus
);
    localparam int unsigned CNT_WIDTH = (TIMEOUT_CYCLES != 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_EN ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  cmd_ready;

    // Held low while reset is asserted, otherwise purely from registered state.
    assign cmd_ready = PRESETn && (state_q == IDLE) && !rsp_valid_q;

    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        cnt_d       = cnt_q;

        if (rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready) begin
                    state_d   = SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    paddr_d   = bus.cmd_addr;
                    pwrite_d  = bus.cmd_write;
                    pwdata_d  = bus.cmd_write ? bus.cmd_wdata : '0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
                cnt_d     = '0;
            end
            ACCESS: begin
                // PREADY is tested first so it wins on the edge the timeout would fire.
                if (bus.PREADY) begin
                    state_d     = IDLE;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = pwrite_q ? '0 : bus.PRDATA;
                end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
                    state_d     = IDLE;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PWDATA    = pwdata_q;
endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: behavioural APB slave with programmable wait states,
// bus-protocol monitor, and hand-computed expectations for each scenario.
module tb_apb_master_bridge;
    localparam logic [31:0] JUNK = 32'hA5A5_A5A5;

    logic PCLK;
    logic PRESETn;

    apb_master_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    apb_master_bridge #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .PCLK   (PCLK),
        .PRESETn(PRESETn),
        .bus    (bus)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave: PREADY rises after wait_target ACCESS cycles; PRDATA is junk except on a ready read.
    int          wait_target = 0;
    int          acc_cnt     = 0;
    bit          mem_init    = 1'b0;
    logic [31:0] mem [16];

    always @(negedge PCLK) begin
        if (!mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] = 32'hC0DE_0000 + i;
            mem[9]   = 32'h1234_5678;
            mem_init = 1'b1;
        end
        if (bus.PSEL && bus.PENABLE) begin
            if (acc_cnt >= wait_target) begin
                bus.PREADY = 1'b1;
                if (bus.PWRITE) begin
                    mem[bus.PADDR[5:2]] = bus.PWDATA;
                    bus.PRDATA = JUNK;
                end else begin
                    bus.PRDATA = mem[bus.PADDR[5:2]];
                end
            end else begin
                bus.PREADY = 1'b0;
                bus.PRDATA = JUNK;
            end
            acc_cnt++;
        end else begin
            bus.PREADY = 1'b0;
            bus.PRDATA = JUNK;
            acc_cnt    = 0;
        end
    end

    // Monitor: protocol violations and PSEL-low gap lengths between transfers.
    int          viol = 0;
    logic        psel_prev = 1'b0;
    logic [31:0] paddr_prev, pwdata_prev;
    logic        pwrite_prev;
    bit          gap_on = 1'b0, gap_on_prev = 1'b0;
    int          gap_run = 0, gap_min = 1000, gap_max = 0;

    always @(negedge PCLK) begin
        if (bus.PENABLE && !bus.PSEL) viol++;
        if (bus.PSEL && !psel_prev && bus.PENABLE) viol++;
        if (bus.PSEL && psel_prev &&
            (bus.PADDR !== paddr_prev || bus.PWDATA !== pwdata_prev || bus.PWRITE !== pwrite_prev)) viol++;
        if (gap_on && !gap_on_prev) begin
            gap_min = 1000;
            gap_max = 0;
        end
        if (!bus.PSEL) begin
            gap_run++;
        end else begin
            if (gap_on && gap_run > 0) begin
                if (gap_run < gap_min) gap_min = gap_run;
                if (gap_run > gap_max) gap_max = gap_run;
            end
            gap_run = 0;
        end
        gap_on_prev = gap_on;
        psel_prev   = bus.PSEL;
        paddr_prev  = bus.PADDR;
        pwdata_prev = bus.PWDATA;
        pwrite_prev = bus.PWRITE;
    end

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Issue one command, wait (bounded) for the response; lat counts edges after the accept edge.
    task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           output int lat, output int en_cyc, output logic [31:0] rdata,
                           output logic err, output logic psel_at_rsp);
        check("cmd_ready_before_accept", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        tick();
        bus.cmd_valid = 1'b0;
        lat    = 0;
        en_cyc = 0;
        while (!bus.rsp_valid && lat < 40) begin
            if (bus.PENABLE) en_cyc++;
            tick();
            lat++;
        end
        rdata       = bus.rsp_rdata;
        err         = bus.rsp_err;
        psel_at_rsp = bus.PSEL;
        if (bus.rsp_ready) tick();
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got no finish expected finish within 50000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          lat, en;
        logic [31:0] rd, last_w;
        logic        er, ps;

        PRESETn       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) tick();

        check("reset_cmd_ready", bus.cmd_ready, 0);
        check("reset_psel", bus.PSEL, 0);
        check("reset_penable", bus.PENABLE, 0);
        check("reset_rsp_valid", bus.rsp_valid, 0);
        check("reset_paddr", bus.PADDR, 0);
        check("reset_pwdata", bus.PWDATA, 0);
        check("reset_rsp_err", bus.rsp_err, 0);
        PRESETn = 1'b1;
        tick();
        check("post_reset_cmd_ready", bus.cmd_ready, 1);

        // Zero-wait write, cycle by cycle
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 32'h10;
        bus.cmd_wdata = 32'hDEAD_BEEF;
        tick();
        bus.cmd_valid = 1'b0;
        check("wr_setup_psel", bus.PSEL, 1);
        check("wr_setup_penable", bus.PENABLE, 0);
        check("wr_setup_paddr", bus.PADDR, 32'h10);
        check("wr_setup_pwdata", bus.PWDATA, 32'hDEAD_BEEF);
        check("wr_setup_pwrite", bus.PWRITE, 1);
        tick();
        check("wr_access_psel", bus.PSEL, 1);
        check("wr_access_penable", bus.PENABLE, 1);
        check("wr_access_paddr", bus.PADDR, 32'h10);
        check("wr_access_pwdata", bus.PWDATA, 32'hDEAD_BEEF);
        tick();
        check("wr_done_psel", bus.PSEL, 0);
        check("wr_done_penable", bus.PENABLE, 0);
        check("wr_rsp_valid", bus.rsp_valid, 1);
        check("wr_rsp_err", bus.rsp_err, 0);
        check("wr_rsp_rdata", bus.rsp_rdata, 0);
        check("wr_paddr_retained", bus.PADDR, 32'h10);
        check("wr_cmd_ready_pending", bus.cmd_ready, 0);
        tick();
        check("wr_rsp_consumed", bus.rsp_valid, 0);
        check("wr_cmd_ready_again", bus.cmd_ready, 1);

        // Read with 3 wait states; PREADY arrives on the cycle the timeout would fire
        wait_target = 3;
        do_xfer(1'b0, 32'h24, 32'hFFFF_FFFF, lat, en, rd, er, ps);
        check("rdw_latency", lat, 5);
        check("rdw_penable_cycles", en, 4);
        check("rdw_rdata", rd, 32'h1234_5678);
        check("rdw_err", er, 0);

        // Stuck slave: aborted after 4 ACCESS cycles
        wait_target = 1000;
        do_xfer(1'b0, 32'h08, 32'h0, lat, en, rd, er, ps);
        check("to_latency", lat, 5);
        check("to_penable_cycles", en, 4);
        check("to_err", er, 1);
        check("to_rdata", rd, 0);
        check("to_psel", ps, 0);
        wait_target = 0;
        do_xfer(1'b0, 32'h0C, 32'h0, lat, en, rd, er, ps);
        check("after_to_latency", lat, 2);
        check("after_to_rdata", rd, 32'hC0DE_0003);
        check("after_to_err", er, 0);

        // Response backpressure with a command waiting
        bus.rsp_ready = 1'b0;
        do_xfer(1'b0, 32'h24, 32'h0, lat, en, rd, er, ps);
        check("bp_latency", lat, 2);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 32'h04;
        bus.cmd_wdata = 32'h55AA_55AA;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_cmd_ready", bus.cmd_ready, 0);
            check("bp_psel", bus.PSEL, 0);
            check("bp_rsp_valid", bus.rsp_valid, 1);
            check("bp_rsp_rdata", bus.rsp_rdata, 32'h1234_5678);
        end
        bus.rsp_ready = 1'b1;
        tick();
        check("bp_release_rsp_valid", bus.rsp_valid, 0);
        check("bp_release_cmd_ready", bus.cmd_ready, 1);
        check("bp_release_psel", bus.PSEL, 0);
        tick();
        bus.cmd_valid = 1'b0;
        check("bp_next_psel", bus.PSEL, 1);
        check("bp_next_paddr", bus.PADDR, 32'h04);
        check("bp_next_pwrite", bus.PWRITE, 1);
        tick();
        tick();
        check("bp_next_rsp_valid", bus.rsp_valid, 1);
        check("bp_next_rsp_err", bus.rsp_err, 0);
        tick();

        // Reset while in ACCESS
        wait_target   = 1000;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h0C;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        check("rst_mid_penable_before", bus.PENABLE, 1);
        #2;
        PRESETn = 1'b0;
        #1;
        check("rst_mid_psel", bus.PSEL, 0);
        check("rst_mid_penable", bus.PENABLE, 0);
        check("rst_mid_rsp_valid", bus.rsp_valid, 0);
        check("rst_mid_cmd_ready", bus.cmd_ready, 0);
        tick();
        PRESETn     = 1'b1;
        wait_target = 0;
        tick();
        check("rst_after_cmd_ready", bus.cmd_ready, 1);
        check("rst_after_no_rsp", bus.rsp_valid, 0);
        do_xfer(1'b0, 32'h10, 32'h0, lat, en, rd, er, ps);
        check("rst_after_latency", lat, 2);
        check("rst_after_rdata", rd, 32'hDEAD_BEEF);

        // Back-to-back write/read stream; each read targets the preceding write
        last_w = '0;
        for (int i = 0; i < 8; i++) begin
            if (i == 1) gap_on = 1'b1;
            if (i % 2 == 0) begin
                last_w = 32'hA000_0000 + 32'(i) * 32'h111;
                do_xfer(1'b1, 32'(4 * i), last_w, lat, en, rd, er, ps);
                check("stream_wr_rdata", rd, 0);
            end else begin
                do_xfer(1'b0, 32'(4 * (i - 1)), 32'h0, lat, en, rd, er, ps);
                check("stream_rd_rdata", rd, last_w);
            end
            check("stream_latency", lat, 2);
            check("stream_err", er, 0);
        end
        gap_on = 1'b0;
        // Handshake edge then accept edge: PSEL is low for the response cycle and the ready cycle.
        check("stream_gap_min", gap_min, 2);
        check("stream_gap_max", gap_max, 2);
        check("protocol_violations", viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
